candy_sram_arbiter: RTL and testbench

Two-port arbiter and access sequencer for the single-ported data SRAM. It shares the SRAM between the writeback store path (port 0) and the load path (port 1). It serialises their requests, drives the SRAM control, address and data lines for a fixed number of wait cycles, and returns a one-cycle acknowledge with read data. It sits between the writeback/load stages and the SRAM macro.

---
 rtl/candy_sram_arbiter_pkg.sv | 25 ++
 rtl/candy_sram_arbiter_if.sv | 36 +++
 rtl/candy_rr_pick.sv | 27 ++
 rtl/candy_sram_arbiter.sv | 137 +++++++++++++
 tb/tb_candy_sram_arbiter.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/candy_sram_arbiter_pkg.sv
// Shared types and widths for the candy data-SRAM arbiter.
// Optional feature macro: CANDY_ARB_RR_EN (round-robin arbitration).
package candy_sram_arbiter_pkg;

  localparam int unsigned SRAMAddrWidth = 16;
  localparam int unsigned SRAMDataWidth = 32;
  localparam int unsigned ArbCntWidth   = 4;

  typedef enum logic [1:0] {
    ArbIdle   = 2'b00,
    ArbAccess = 2'b01,
    ArbDone   = 2'b10
  } arb_state_e;

  localparam logic ArbPort0 = 1'b0;
  localparam logic ArbPort1 = 1'b1;

  // Request payload captured at grant time and replayed onto the SRAM pins.
  typedef struct packed {
    logic                     we;
    logic [SRAMAddrWidth-1:0] addr;
    logic [SRAMDataWidth-1:0] wdata;
  } arb_req_t;

endpackage

// File: rtl/candy_sram_arbiter_if.sv
// Requester and SRAM-side signal bundle of the candy data-SRAM arbiter.
// Optional feature macro: CANDY_ARB_RR_EN (no effect on this interface).
interface candy_sram_arbiter_if;
  import candy_sram_arbiter_pkg::*;

  logic                     req0;
  logic                     we0;
  logic [SRAMAddrWidth-1:0] addr0;
  logic [SRAMDataWidth-1:0] wdata0;
  logic                     ack0;
  logic                     req1;
  logic                     we1;
  logic [SRAMAddrWidth-1:0] addr1;
  logic [SRAMDataWidth-1:0] wdata1;
  logic                     ack1;
  logic [SRAMDataWidth-1:0] rdata;
  logic                     sram_ce;
  logic                     sram_we;
  logic [SRAMAddrWidth-1:0] sram_addr;
  logic [SRAMDataWidth-1:0] sram_wdata;
  logic [SRAMDataWidth-1:0] sram_rdata;
  logic                     busy;

  // Arbiter side.
  modport slave (
    input  req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, sram_rdata,
    output ack0, ack1, rdata, sram_ce, sram_we, sram_addr, sram_wdata, busy
  );

  // Requester / SRAM macro side.
  modport master (
    output req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, sram_rdata,
    input  ack0, ack1, rdata, sram_ce, sram_we, sram_addr, sram_wdata, busy
  );

endinterface

// File: rtl/candy_rr_pick.sv
// Combinational 2-way winner select for the data-SRAM arbiter.
// Optional feature macro: CANDY_ARB_RR_EN; when undefined, port 0 always wins
// and the pointer input does not exist.
module candy_rr_pick
  import candy_sram_arbiter_pkg::*;
(
  input  logic req0,
  input  logic req1,
`ifdef CANDY_ARB_RR_EN
  input  logic ptr,
`endif
  output logic grant_c,
  output logic winner_c
);

  // Any request means an access will start.
  assign grant_c = req0 | req1;

`ifdef CANDY_ARB_RR_EN
  // On contention the pointer (preferred port) decides; otherwise the lone requester.
  assign winner_c = (req0 && req1) ? ptr : (req1 ? ArbPort1 : ArbPort0);
`else
  // Stores on port 0 always take precedence over loads.
  assign winner_c = req0 ? ArbPort0 : ArbPort1;
`endif

endmodule

// File: rtl/candy_sram_arbiter.sv
// Two-port arbiter and access sequencer for the single-ported data SRAM.
// Optional feature macro: CANDY_ARB_RR_EN selects round-robin arbitration;
// undefined gives fixed priority to port 0 with no pointer register.
module candy_sram_arbiter
  import candy_sram_arbiter_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 1
) (
  input logic            clk,
  input logic            rst,
  candy_sram_arbiter_if.slave bus
);

  localparam logic [ArbCntWidth-1:0] CntLoad = ArbCntWidth'(WAIT_CYCLES - 1);

  arb_state_e               state_q, state_d;
  logic [ArbCntWidth-1:0]   cnt_q, cnt_d;
  arb_req_t                 lat_q, lat_d;
  logic                     win_q, win_d;
  logic [SRAMDataWidth-1:0] rdata_q, rdata_d;
  logic                     ack0_q, ack0_d;
  logic                     ack1_q, ack1_d;
  logic                     ce_q, ce_d;
  logic                     swe_q, swe_d;
  logic                     busy_q, busy_d;
  logic                     grant_c;
  logic                     winner_c;
`ifdef CANDY_ARB_RR_EN
  logic                     ptr_q, ptr_d;
`endif

  candy_rr_pick u_pick (
    .req0     (bus.req0),
    .req1     (bus.req1),
`ifdef CANDY_ARB_RR_EN
    .ptr      (ptr_q),
`endif
    .grant_c  (grant_c),
    .winner_c (winner_c)
  );

  // Next state, latched request and next values of the registered outputs.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lat_d   = lat_q;
    win_d   = win_q;
    rdata_d = rdata_q;
    ack0_d  = 1'b0;
    ack1_d  = 1'b0;
    ce_d    = 1'b0;
    swe_d   = 1'b0;
`ifdef CANDY_ARB_RR_EN
    ptr_d   = ptr_q;
`endif
    unique case (state_q)
      ArbIdle: begin
        if (grant_c) begin
          win_d       = winner_c;
          lat_d.we    = (winner_c == ArbPort1) ? bus.we1    : bus.we0;
          lat_d.addr  = (winner_c == ArbPort1) ? bus.addr1  : bus.addr0;
          lat_d.wdata = (winner_c == ArbPort1) ? bus.wdata1 : bus.wdata0;
          cnt_d       = CntLoad;
          state_d     = ArbAccess;
          ce_d        = 1'b1;
          swe_d       = lat_d.we;
        end
      end
      ArbAccess: begin
        if (cnt_q == '0) begin
          if (!lat_q.we) begin
            rdata_d = bus.sram_rdata;
          end
          state_d = ArbDone;
          ack0_d  = (win_q == ArbPort0);
          ack1_d  = (win_q == ArbPort1);
        end else begin
          cnt_d = cnt_q - ArbCntWidth'(1);
          ce_d  = 1'b1;
          swe_d = lat_q.we;
        end
      end
      ArbDone: begin
        state_d = ArbIdle;
`ifdef CANDY_ARB_RR_EN
        ptr_d   = ~win_q;
`endif
      end
      default: state_d = ArbIdle;
    endcase
    busy_d = (state_d != ArbIdle);
  end

  // State, counter, latched request and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ArbIdle;
      cnt_q   <= '0;
      lat_q   <= '0;
      win_q   <= ArbPort0;
      rdata_q <= '0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      ce_q    <= 1'b0;
      swe_q   <= 1'b0;
      busy_q  <= 1'b0;
`ifdef CANDY_ARB_RR_EN
      ptr_q   <= ArbPort0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lat_q   <= lat_d;
      win_q   <= win_d;
      rdata_q <= rdata_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
      ce_q    <= ce_d;
      swe_q   <= swe_d;
      busy_q  <= busy_d;
`ifdef CANDY_ARB_RR_EN
      ptr_q   <= ptr_d;
`endif
    end
  end

  // SRAM address/data come straight from the latch so they hold between accesses.
  assign bus.ack0       = ack0_q;
  assign bus.ack1       = ack1_q;
  assign bus.rdata      = rdata_q;
  assign bus.sram_ce    = ce_q;
  assign bus.sram_we    = swe_q;
  assign bus.sram_addr  = lat_q.addr;
  assign bus.sram_wdata = lat_q.wdata;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_candy_sram_arbiter.sv
// Self-checking bench for candy_sram_arbiter: directed scenarios plus random
// two-port traffic against a transaction-level model and an SRAM model.
// Optional feature macro: CANDY_ARB_RR_EN (the model follows the same build).
module tb_candy_sram_arbiter;
  import candy_sram_arbiter_pkg::*;

  localparam int unsigned W = 3;

  logic clk;
  logic rst;

  candy_sram_arbiter_if bus();

  candy_sram_arbiter #(.WAIT_CYCLES(W)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic                     req   [2];
  logic                     we    [2];
  logic [SRAMAddrWidth-1:0] addr  [2];
  logic [SRAMDataWidth-1:0] wdata [2];

  assign bus.req0   = req[0];
  assign bus.we0    = we[0];
  assign bus.addr0  = addr[0];
  assign bus.wdata0 = wdata[0];
  assign bus.req1   = req[1];
  assign bus.we1    = we[1];
  assign bus.addr1  = addr[1];
  assign bus.wdata1 = wdata[1];

  logic [SRAMDataWidth-1:0] mem     [256];
  logic [SRAMDataWidth-1:0] ref_mem [256];

  int checks;
  int errors;
  int cyc;
  int ack_cnt [2];
  bit rand_en;
  bit hold_all;

  // Model: k = cycles since the grant edge (0 = idle, 1..W access, W+1 ack).
  int unsigned              k;
  logic                     win;
  logic                     last;
  logic                     m_we;
  logic [SRAMAddrWidth-1:0] m_addr;
  logic [SRAMDataWidth-1:0] m_wdata;
  logic [SRAMDataWidth-1:0] m_rdata;

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    k       = 0;
    last    = 1'b1;
    win     = 1'b0;
    m_we    = 1'b0;
    m_addr  = '0;
    m_wdata = '0;
    m_rdata = '0;
  endtask

  task automatic model_step();
    if (k == 0) begin
      if (req[0] || req[1]) begin
`ifdef CANDY_ARB_RR_EN
        if (req[0] && req[1]) win = ~last;
        else                  win = req[1];
`else
        win = req[0] ? 1'b0 : 1'b1;
`endif
        m_we    = we[win];
        m_addr  = addr[win];
        m_wdata = wdata[win];
        k       = 1;
      end
    end else if (k == W + 1) begin
      k = 0;
    end else begin
      k++;
      if (k == W + 1) begin
        last = win;
        if (m_we) ref_mem[m_addr[7:0]] = m_wdata;
        else      m_rdata = ref_mem[m_addr[7:0]];
      end
    end
  endtask

  task automatic check_all();
    check("busy",       32'(bus.busy),       32'(k != 0));
    check("sram_ce",    32'(bus.sram_ce),    32'(k >= 1 && k <= W));
    check("sram_we",    32'(bus.sram_we),    32'(k >= 1 && k <= W && m_we));
    check("sram_addr",  32'(bus.sram_addr),  32'(m_addr));
    check("sram_wdata", bus.sram_wdata,      m_wdata);
    check("ack0",       32'(bus.ack0),       32'(k == W + 1 && win == 1'b0));
    check("ack1",       32'(bus.ack1),       32'(k == W + 1 && win == 1'b1));
    check("rdata",      bus.rdata,           m_rdata);
  endtask

  task automatic sram_side();
    if (bus.sram_ce && bus.sram_we) mem[bus.sram_addr[7:0]] = bus.sram_wdata;
    bus.sram_rdata = (k == W && bus.sram_ce && !bus.sram_we) ? mem[bus.sram_addr[7:0]]
                                                              : $urandom;
  endtask

  task automatic drive_clients();
    for (int p = 0; p < 2; p++) begin
      if (k == W + 1 && win == 1'(p)) begin
        if (!hold_all && !(rand_en && $urandom_range(0, 7) == 0)) req[p] = 1'b0;
      end else if (rand_en && !req[p] && $urandom_range(0, 2) == 0) begin
        req[p]   = 1'b1;
        we[p]    = 1'($urandom_range(0, 1));
        addr[p]  = SRAMAddrWidth'($urandom);
        wdata[p] = $urandom;
      end
    end
    if (rand_en && k != 0 && $urandom_range(0, 2) == 0) begin
      addr[win]  = SRAMAddrWidth'($urandom);
      wdata[win] = $urandom;
      we[win]    = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    cyc++;
    check_all();
    ack_cnt[0] += int'(bus.ack0);
    ack_cnt[1] += int'(bus.ack1);
    sram_side();
    drive_clients();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    check_all();
    rst = 1'b0;
  endtask

  initial begin
    clk      = 1'b0;
    rst      = 1'b1;
    checks   = 0;
    errors   = 0;
    cyc      = 0;
    rand_en  = 1'b0;
    hold_all = 1'b0;
    for (int p = 0; p < 2; p++) begin
      req[p] = 1'b0; we[p] = 1'b0; addr[p] = '0; wdata[p] = '0; ack_cnt[p] = 0;
    end
    for (int i = 0; i < 256; i++) begin
      mem[i]     = $urandom;
      ref_mem[i] = mem[i];
    end
    mem[8'h20]     = 32'h1234_5678;
    ref_mem[8'h20] = 32'h1234_5678;
    bus.sram_rdata = '0;
    model_reset();

    // Reset values.
    @(negedge clk);
    check_all();
    rst = 1'b0;

    // Single write on port 0.
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 16'h0010; wdata[0] = 32'hDEAD_BEEF;
    tick();
    check("wr_addr",   32'(bus.sram_addr), 32'h0000_0010);
    check("wr_data",   bus.sram_wdata,     32'hDEAD_BEEF);
    check("wr_strobe", 32'({bus.sram_ce, bus.sram_we}), 32'h3);
    ack_cnt[0] = 0; ack_cnt[1] = 0;
    run(W + 2);
    check("wr_ack0_count", 32'(ack_cnt[0]), 32'd1);

    // Single read on port 1.
    req[1] = 1'b1; we[1] = 1'b0; addr[1] = 16'h0020;
    run(W + 1);
    check("rd_ack1", 32'(bus.ack1), 32'd1);
    check("rd_data", bus.rdata, 32'h1234_5678);
    run(2);

    // Payload change during ACCESS must not reach the SRAM pins.
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 16'h0030; wdata[0] = 32'h0BAD_F00D;
    tick();
    addr[0] = 16'hFFFF; wdata[0] = 32'h1111_1111;
    tick();
    check("hold_addr",  32'(bus.sram_addr), 32'h0000_0030);
    check("hold_wdata", bus.sram_wdata,     32'h0BAD_F00D);
    run(W + 1);

    // Both ports held: grant order across four accesses.
    req[0] = 1'b1; we[0] = 1'b0; addr[0] = 16'h0041;
    req[1] = 1'b1; we[1] = 1'b0; addr[1] = 16'h0052;
    hold_all = 1'b1;
    ack_cnt[0] = 0; ack_cnt[1] = 0;
    run(4 * (W + 2));
    hold_all = 1'b0;
    req[0] = 1'b0; req[1] = 1'b0;
`ifdef CANDY_ARB_RR_EN
    check("alt_ack0_count", 32'(ack_cnt[0]), 32'd2);
    check("alt_ack1_count", 32'(ack_cnt[1]), 32'd2);
`else
    check("alt_ack0_count", 32'(ack_cnt[0]), 32'd4);
    check("alt_ack1_count", 32'(ack_cnt[1]), 32'd0);
`endif
    run(2);

    // Reset during ACCESS: pointer returns to port 0.
    req[0] = 1'b1; we[0] = 1'b0; addr[0] = 16'h0063;
    run(W + 3);
    req[0] = 1'b1; we[0] = 1'b0; addr[0] = 16'h0074;
    req[1] = 1'b1; we[1] = 1'b0; addr[1] = 16'h0085;
    run(2);
    apply_reset();
    ack_cnt[0] = 0; ack_cnt[1] = 0;
    run(W + 2);
    check("rst_regrant_ack0", 32'(ack_cnt[0]), 32'd1);
    check("rst_regrant_ack1", 32'(ack_cnt[1]), 32'd0);
    run(W + 3);

    // Random two-port traffic, including held requests.
    rand_en = 1'b1;
    run(1500);
    rand_en = 1'b0;
    run(40);
    check("drain_idle", 32'(bus.busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
